// File: rtl/s5378_cone_seq.sv
// ----------------------------------------------------------------------------
// s5378_cone_seq
//
// Purpose:
//   Sequencer that feeds an external combinational cone. A start request in
//   IDLE latches a 6-bit phase seed, a 9-bit parity-group vector and a 3-bit
//   mode vector. The phase register then rotates left once per clock for six
//   clocks. On each of those clocks the cone result n3119gat is sampled. On the
//   sixth sample the sequence result is published for one cycle through
//   result_valid. After six rotations the phase register is back at the seed.
//
// Configuration:
//   S5378_CONE_SEQ_PARITY_ACC_EN
//     defined   : result is the XOR of all six n3119gat samples.
//     undefined : the accumulator is removed, and result is the n3119gat
//                 value sampled on the final shift edge.
//   Timing is the same in both builds.
//
// Handshake:
//   start is a level request. It is taken only in IDLE, and only when abort
//   is low on the same edge. abort acts only in SHIFT: it returns the block to
//   IDLE and does not strobe result_valid. result_valid is high for exactly
//   one cycle per completed sequence, and result holds its value until the
//   next completed sequence.
//
// Ports:
//   CK                    in   clock, rising edge
//   rst_n                 in   asynchronous active-low reset
//   start, abort          in   sequence request / cancel
//   seed[5:0]             in   phase register initial value
//   data_in[8:0]          in   parity-group vector, latched at start
//   mode_in[2:0]          in   mode vector, latched at start
//   n3119gat              in   cone result fed back from downstream
//   n3083gat..n3088gat    out  phase register bits 0..5
//   n3093gat              out  shift-active flag
//   n3095gat              out  sequence-enable flag
//   n1294gat..n1148gat    out  registered data_in[0]..[8]
//   n160gat,n553gat,n816gat out registered mode_in[0]..[2]
//   busy                  out  high while in SHIFT
//   result, result_valid  out  sequence result and its one-cycle strobe
//   o_dbg_state[1:0]      out  FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// ----------------------------------------------------------------------------
module s5378_cone_seq (
    input  logic       CK,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] seed,
    input  logic [8:0] data_in,
    input  logic [2:0] mode_in,
    input  logic       n3119gat,
    output logic       n3083gat,
    output logic       n3084gat,
    output logic       n3085gat,
    output logic       n3086gat,
    output logic       n3087gat,
    output logic       n3088gat,
    output logic       n3093gat,
    output logic       n3095gat,
    output logic       n1294gat,
    output logic       n1241gat,
    output logic       n1298gat,
    output logic       n1068gat,
    output logic       n861gat,
    output logic       n957gat,
    output logic       n865gat,
    output logic       n1080gat,
    output logic       n1148gat,
    output logic       n160gat,
    output logic       n553gat,
    output logic       n816gat,
    output logic       busy,
    output logic       result,
    output logic       result_valid,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t     r_state;
    logic [5:0] r_phase;
    logic [8:0] r_data;
    logic [2:0] r_mode;
    logic [2:0] r_cnt;
    logic       r_n3093;
    logic       r_n3095;
    logic       r_busy;
    logic       r_result;
    logic       r_result_valid;
    logic       w_final_res;

`ifdef S5378_CONE_SEQ_PARITY_ACC_EN
    logic       r_acc;
    // The final sample folds straight into the published result, so the
    // accumulator never needs to hold all six samples.
    assign w_final_res = r_acc ^ n3119gat;
`else
    assign w_final_res = n3119gat;
`endif

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_phase        <= 6'd0;
            r_data         <= 9'd0;
            r_mode         <= 3'd0;
            r_cnt          <= 3'd0;
            r_n3093        <= 1'b0;
            r_n3095        <= 1'b0;
            r_busy         <= 1'b0;
            r_result       <= 1'b0;
            r_result_valid <= 1'b0;
`ifdef S5378_CONE_SEQ_PARITY_ACC_EN
            r_acc          <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A start that coincides with abort is dropped.
                    if (start && !abort) begin
                        r_phase <= seed;
                        r_data  <= data_in;
                        r_mode  <= mode_in;
                        r_n3093 <= 1'b1;
                        r_n3095 <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= 3'd0;
`ifdef S5378_CONE_SEQ_PARITY_ACC_EN
                        r_acc   <= 1'b0;
`endif
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        // Cancel: phase, data and result keep their values.
                        r_n3093 <= 1'b0;
                        r_n3095 <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
`ifdef S5378_CONE_SEQ_PARITY_ACC_EN
                        r_acc   <= r_acc ^ n3119gat;
`endif
                        r_phase <= {r_phase[4:0], r_phase[5]};
                        r_cnt   <= r_cnt + 3'd1;
                        // cnt==5 marks the sixth and last sample.
                        if (r_cnt == 3'd5) begin
                            r_result       <= w_final_res;
                            r_result_valid <= 1'b1;
                            r_n3093        <= 1'b0;
                            r_busy         <= 1'b0;
                            r_state        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_n3095        <= 1'b0;
                    r_result_valid <= 1'b0;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign n3083gat     = r_phase[0];
    assign n3084gat     = r_phase[1];
    assign n3085gat     = r_phase[2];
    assign n3086gat     = r_phase[3];
    assign n3087gat     = r_phase[4];
    assign n3088gat     = r_phase[5];
    assign n3093gat     = r_n3093;
    assign n3095gat     = r_n3095;
    assign n1294gat     = r_data[0];
    assign n1241gat     = r_data[1];
    assign n1298gat     = r_data[2];
    assign n1068gat     = r_data[3];
    assign n861gat      = r_data[4];
    assign n957gat      = r_data[5];
    assign n865gat      = r_data[6];
    assign n1080gat     = r_data[7];
    assign n1148gat     = r_data[8];
    assign n160gat      = r_mode[0];
    assign n553gat      = r_mode[1];
    assign n816gat      = r_mode[2];
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_s5378_cone_seq.sv
// ----------------------------------------------------------------------------
// tb_s5378_cone_seq
//
// Bench for s5378_cone_seq. Each clock, the bench compares the full output
// vector with a transaction-level reference model. The model tracks the
// latched seed, the number of rotations taken, and the list of n3119gat samples.
// The phase is computed as a rotation of the seed, and the result is computed
// from the sample list. Completed results also go through an expected queue
// that is drained on result_valid.
// ----------------------------------------------------------------------------
module tb_s5378_cone_seq;

    // ---------------- clock / reset ----------------
    logic       CK = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] seed = 6'd0;
    logic [8:0] data_in = 9'd0;
    logic [2:0] mode_in = 3'd0;
    logic       n3119gat = 1'b0;

    logic n3083gat, n3084gat, n3085gat, n3086gat, n3087gat, n3088gat;
    logic n3093gat, n3095gat;
    logic n1294gat, n1241gat, n1298gat, n1068gat, n861gat, n957gat;
    logic n865gat, n1080gat, n1148gat;
    logic n160gat, n553gat, n816gat;
    logic busy, result, result_valid;
    logic [1:0] o_dbg_state;

    always #5 CK = ~CK;

    s5378_cone_seq dut (
        .CK(CK), .rst_n(rst_n), .start(start), .abort(abort),
        .seed(seed), .data_in(data_in), .mode_in(mode_in), .n3119gat(n3119gat),
        .n3083gat(n3083gat), .n3084gat(n3084gat), .n3085gat(n3085gat),
        .n3086gat(n3086gat), .n3087gat(n3087gat), .n3088gat(n3088gat),
        .n3093gat(n3093gat), .n3095gat(n3095gat),
        .n1294gat(n1294gat), .n1241gat(n1241gat), .n1298gat(n1298gat),
        .n1068gat(n1068gat), .n861gat(n861gat), .n957gat(n957gat),
        .n865gat(n865gat), .n1080gat(n1080gat), .n1148gat(n1148gat),
        .n160gat(n160gat), .n553gat(n553gat), .n816gat(n816gat),
        .busy(busy), .result(result), .result_valid(result_valid),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vectors = 0;
    int n_miscompares = 0;
    logic [0:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_active, m_done, m_f3093, m_f3095, m_result, m_rv;
    logic [5:0] m_seed;
    logic [8:0] m_data;
    logic [2:0] m_mode;
    int         m_k;
    logic       m_samples[$];

    function automatic logic [5:0] rotl(input logic [5:0] s, input int k);
        int v;
        int r;
        v = int'(s);
        r = k % 6;
        if (r == 0) return s;
        return 6'(((v << r) | (v >> (6 - r))) & 63);
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_f3093 = 0; m_f3095 = 0;
        m_result = 0; m_rv = 0; m_seed = 0; m_data = 0; m_mode = 0;
        m_k = 0; m_samples.delete();
    endtask

    function automatic logic final_result();
        int ones;
`ifdef S5378_CONE_SEQ_PARITY_ACC_EN
        ones = 0;
        foreach (m_samples[i]) ones += int'(m_samples[i]);
        return logic'(ones % 2);
`else
        ones = 0;
        return m_samples[m_samples.size() - 1];
`endif
    endfunction

    task automatic model_edge();
        if (m_done) begin
            m_done = 0; m_rv = 0; m_f3095 = 0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 0; m_f3093 = 0; m_f3095 = 0;
            end else begin
                m_samples.push_back(n3119gat);
                m_k++;
                if (m_k == 6) begin
                    m_active = 0; m_done = 1; m_rv = 1; m_f3093 = 0;
                    m_result = final_result();
                    exp_q.push_back(m_result);
                end
            end
        end else if (start && !abort) begin
            m_seed = seed; m_data = data_in; m_mode = mode_in;
            m_k = 0; m_samples.delete();
            m_active = 1; m_f3093 = 1; m_f3095 = 1;
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {9'd0,
                n3088gat, n3087gat, n3086gat, n3085gat, n3084gat, n3083gat,
                n3093gat, n3095gat,
                n1148gat, n1080gat, n865gat, n957gat, n861gat, n1068gat,
                n1298gat, n1241gat, n1294gat,
                n816gat, n553gat, n160gat,
                busy, result, result_valid};
    endfunction

    function automatic logic [31:0] model_vec();
        return {9'd0, rotl(m_seed, m_k), m_f3093, m_f3095, m_data, m_mode,
                m_active, m_result, m_rv};
    endfunction

    task automatic compare_outputs(input string tag);
        logic [0:0] e;
        check_eq(tag, dut_vec(), model_vec());
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("rv_unexpected", 32'(result_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("result_on_rv", 32'(result), 32'(e));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input string tag);
        @(posedge CK);
        if (rst_n) model_edge();
        #1;
        compare_outputs(tag);
        @(negedge CK);
    endtask

    task automatic drive(input logic st, input logic ab, input logic cone);
        start = st; abort = ab; n3119gat = cone;
    endtask

    task automatic load(input logic [5:0] s, input logic [8:0] d, input logic [2:0] m);
        seed = s; data_in = d; mode_in = m;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs("async_reset");
        @(negedge CK);
        tick("in_reset");
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(negedge CK);
        apply_reset();

        // Known seed, cone held at 1.
        load(6'b000001, 9'h1A5, 3'b101);
        drive(1, 0, 1);
        tick("dir_start");
        drive(0, 0, 1);
        for (int i = 0; i < 7; i++) tick("dir_walk");
`ifdef S5378_CONE_SEQ_PARITY_ACC_EN
        check_eq("dir_held_one", 32'(result), 32'd0);
`else
        check_eq("dir_held_one", 32'(result), 32'd1);
`endif

        // Cone high only before E3.
        load(6'b100110, 9'h0F3, 3'b010);
        drive(1, 0, 0);
        tick("dir2_start");
        for (int i = 1; i <= 7; i++) begin
            drive(0, 0, (i == 3));
            tick("dir2_walk");
        end
`ifdef S5378_CONE_SEQ_PARITY_ACC_EN
        check_eq("dir_single_pulse", 32'(result), 32'd1);
`else
        check_eq("dir_single_pulse", 32'(result), 32'd0);
`endif

        // Abort before E3, and the previous result must stay.
        load(6'b010101, 9'h155, 3'b011);
        drive(1, 0, 1);
        tick("abort_start");
        drive(0, 0, 1); tick("abort_e1");
        drive(0, 0, 1); tick("abort_e2");
        drive(0, 1, 1); tick("abort_e3");
        check_eq("abort_busy", 32'(busy), 32'd0);
        drive(0, 0, 0);
        for (int i = 0; i < 3; i++) tick("abort_idle");

        // start re-pulsed during SHIFT and DONE is ignored.
        load(6'b001011, 9'h0AA, 3'b110);
        drive(1, 0, 1);
        tick("restart_start");
        for (int i = 1; i <= 9; i++) begin
            drive(i <= 7, 0, logic'($urandom_range(0, 1)));
            tick("restart_walk");
        end

        // Reset between E2 and E3, then a full sequence.
        load(6'b110001, 9'h1FF, 3'b111);
        drive(1, 0, 0);
        tick("rst_mid_start");
        drive(0, 0, 1); tick("rst_mid_e1");
        drive(0, 0, 1); tick("rst_mid_e2");
        apply_reset();
        load(6'b000111, 9'h123, 3'b001);
        drive(1, 0, 1);
        tick("post_rst_start");
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, logic'($urandom_range(0, 1)));
            tick("post_rst_walk");
        end

        // start with abort together in IDLE is dropped.
        load(6'b111111, 9'h0F0, 3'b100);
        drive(1, 1, 1);
        tick("start_abort_idle");
        drive(0, 0, 0);
        tick("start_abort_hold");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end else begin
                load(6'($urandom), 9'($urandom), 3'($urandom));
                drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 6),
                      logic'($urandom_range(0, 1)));
                tick("random");
            end
        end

        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/s5378_cone_seq.md
S5378_CONE_SEQ -- requirements
Module: s5378_cone_seq

Interface
REQ-001 Parameters: none; all widths below are fixed.
REQ-002 CK  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new sequence; honoured only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a running sequence.
REQ-006 seed  input  6  initial value of the phase register.
REQ-007 data_in  input  9  parity-group vector, latched at start.
REQ-008 mode_in  input  3  mode vector, latched at start.
REQ-009 n3119gat  input  1  combinational cone result, fed back from the downstream cone.
REQ-010 n3083gat..n3088gat  output  1 each  phase register bits seed[0]..seed[5] after rotation.
REQ-011 n3093gat  output  1  shift-active flag.
REQ-012 n3095gat  output  1  sequence-enable flag.
REQ-013 n1294gat, n1241gat, n1298gat, n1068gat, n861gat, n957gat, n865gat, n1080gat, n1148gat  output  1 each  registered data_in[0]..data_in[8].
REQ-014 n160gat, n553gat, n816gat  output  1 each  registered mode_in[0]..mode_in[2].
REQ-015 busy  output  1  high while in SHIFT.
REQ-016 result  output  1  sequence result.
REQ-017 result_valid  output  1  one-cycle strobe qualifying result.

Function
REQ-018 FSM states: IDLE, SHIFT, DONE. A 3-bit shift counter cnt and a 1-bit accumulator acc are internal.
REQ-019 IDLE, start=1, abort=0 at an edge: the block loads the phase register from seed, data registers from data_in, mode registers from mode_in, sets n3095gat=1 and n3093gat=1, clears cnt and acc, and enters SHIFT.
REQ-020 IDLE, start=0 or abort=1: all registers hold; start with abort in the same cycle is dropped.
REQ-021 SHIFT, each edge with abort=0: acc<=acc^n3119gat (the value sampled before the edge); the phase register rotates left (n3084gat<=n3083gat, ..., n3088gat<=n3087gat, n3083gat<=n3088gat); cnt<=cnt+1.
REQ-022 SHIFT with cnt==5 at an edge: the block enters DONE, sets result<=acc^n3119gat, result_valid<=1, and n3093gat<=0. Exactly six samples are taken.
REQ-023 DONE, next edge: the block enters IDLE, sets n3095gat<=0 and result_valid<=0. result holds until the next completed sequence.
REQ-024 SHIFT with abort=1: the block enters IDLE on the next edge, sets n3093gat<=0 and n3095gat<=0, and does not assert result_valid. result is unchanged and the phase and data registers hold.
REQ-025 start outside IDLE is ignored. abort outside SHIFT is ignored.
REQ-026 Latency: start is sampled at edge E0; result_valid is high for exactly the cycle after edge E6. busy is high after E0 through E6.
REQ-027 After six rotations the phase register equals seed.

Reset
REQ-028 rst_n=0 asynchronously forces state=IDLE and clears cnt, acc, result, result_valid, busy, n3093gat, n3095gat, all phase, data and mode outputs to 0. The reset may assert at any time, including mid-SHIFT.
REQ-029 Reset deassertion has no effect until the first rising CK edge with rst_n=1.

Configuration
REQ-030 Macro S5378_CONE_SEQ_PARITY_ACC_EN: when defined, result is the XOR of all six n3119gat samples (REQ-021/022). When undefined, acc is removed and result<=n3119gat sampled at the cnt==5 edge only. Timing is identical in both builds.

Verification
REQ-031 Reset, then seed=6'b000001, data_in=9'h1A5, mode_in=3'b101, start pulse, n3119gat=1 held:
 - outputs after E1..E5: n3083..n3088 walk 000010, 000100, ... 100000.
 - after E6: phase returns to 000001; result_valid=1 for one cycle.
 - result=0 with the macro, 1 without.
REQ-032 n3119gat=1 only in the cycle before E3, otherwise 0 -> result=1 with the macro, 0 without.
REQ-033 abort=1 before E3 -> after E3: IDLE, busy=0, n3095gat=0, no result_valid, previous result retained.
REQ-034 start re-pulsed during SHIFT and in the DONE cycle -> ignored; the sequence completes at E6 and no second sequence starts without a new start in IDLE.
REQ-035 rst_n asserted between E2 and E3 -> all outputs 0 immediately. A later start after release runs a full six-sample sequence correctly.
REQ-036 start=1 and abort=1 together in IDLE -> remains IDLE with all outputs unchanged.
